lb_reg_bank: RTL and testbench

- Local-bus register bank directly downstream of the APB slave interface.
- Consumes the local-bus write strobe, address and write data; returns read data with a fixed two-clock latency plus a ready flag.
- Holds the control, status, interrupt-enable, scratch, counter and ID registers for one peripheral, and drives the peripheral's control outputs and interrupt.

---
 rtl/lb_reg_pkg.sv | 35 +++
 rtl/lb_rd_pipe.sv | 44 ++++
 rtl/lb_reg_bank.sv | 167 ++++++++++++++++
 tb/tb_lb_reg_bank.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_reg_pkg.sv
// ---------------------------------------------------------------------------
// lb_reg_pkg
// Shared definitions for the local-bus register bank: register byte offsets,
// the 3-bit register index derived from them, and CTRL bit positions.
// ---------------------------------------------------------------------------
package lb_reg_pkg;

    // Register index is lb_aout[4:2]
    typedef logic [2:0] reg_idx_t;

    // Byte offsets inside the 32-byte register window
    localparam logic [4:0] OFS_CTRL    = 5'h00;
    localparam logic [4:0] OFS_STATUS  = 5'h04;
    localparam logic [4:0] OFS_IRQ_EN  = 5'h08;
    localparam logic [4:0] OFS_SCRATCH = 5'h0C;
    localparam logic [4:0] OFS_COUNT   = 5'h10;
    localparam logic [4:0] OFS_ID      = 5'h14;

    // Word indices matching the offsets above
    localparam reg_idx_t IDX_CTRL    = OFS_CTRL[4:2];
    localparam reg_idx_t IDX_STATUS  = OFS_STATUS[4:2];
    localparam reg_idx_t IDX_IRQ_EN  = OFS_IRQ_EN[4:2];
    localparam reg_idx_t IDX_SCRATCH = OFS_SCRATCH[4:2];
    localparam reg_idx_t IDX_COUNT   = OFS_COUNT[4:2];
    localparam reg_idx_t IDX_ID      = OFS_ID[4:2];

    // CTRL bit positions
    localparam int CTRL_CNT_EN  = 0;
    localparam int CTRL_CNT_CLR = 1;
    localparam int CTRL_LOCK    = 31;

    // The counter-clear bit is a pulse and is never stored, so it reads 0
    localparam logic [31:0] CTRL_WR_MASK = ~(32'd1 << CTRL_CNT_CLR);

endpackage

// File: rtl/lb_rd_pipe.sv
// ---------------------------------------------------------------------------
// lb_rd_pipe
// Two-stage read-data delay for the register bank. An address presented in
// cycle N shows up on lb_din / lb_rdyh in cycle N+2. A miss returns zero data
// with lb_rdyh low. Reset flushes both stages.
//
// Ports:
//   pclk     in   clock, rising edge
//   preset   in   asynchronous active-high reset
//   hit      in   address hit the bank this cycle
//   rd_data  in   selected register value this cycle
//   lb_din   out  read data, two clocks later
//   lb_rdyh  out  read data valid, two clocks later
// ---------------------------------------------------------------------------
module lb_rd_pipe (
    input  logic        pclk,
    input  logic        preset,
    input  logic        hit,
    input  logic [31:0] rd_data,
    output logic [31:0] lb_din,
    output logic        lb_rdyh
);

    logic        hit_q;
    logic [31:0] data_q;

    // Stage 1 captures the hit flag and the data (zeroed on a miss); stage 2
    // drives the bus outputs. Both stages are cleared immediately on reset so
    // a read in flight never completes across a reset.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            hit_q   <= 1'b0;
            data_q  <= '0;
            lb_din  <= '0;
            lb_rdyh <= 1'b0;
        end else begin
            hit_q   <= hit;
            data_q  <= hit ? rd_data : '0;
            lb_din  <= data_q;
            lb_rdyh <= hit_q;
        end
    end

endmodule

// File: rtl/lb_reg_bank.sv
// ---------------------------------------------------------------------------
// lb_reg_bank
// Local-bus register bank for one peripheral: CTRL, STATUS (W1C), IRQ_EN,
// SCRATCH, free-running COUNT and a constant ID. Writes are single cycle;
// reads return two clocks after the address with a ready flag.
//
// Ports:
//   pclk      in   clock, rising edge
//   preset    in   asynchronous active-high reset
//   lb_wrout  in   write qualifier
//   lb_cs     in   chip select (write = lb_cs & lb_wrout & hit)
//   lb_aout   in   byte address, [4:2] selects the register
//   lb_dout   in   write data
//   lb_din    out  read data, two clocks after the address
//   lb_rdyh   out  read data valid
//   evt_in    in   hardware event pulses, sampled each clock
//   ctrl_out  out  CTRL register contents
//   irq       out  registered interrupt
//
// Build option: define LB_REG_LOCK_EN to make CTRL[31] a sticky lock that
// blocks further CTRL / IRQ_EN / SCRATCH writes until reset.
// ---------------------------------------------------------------------------
module lb_reg_bank
    import lb_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h0001_0100,
    parameter int          EVT_W     = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             lb_wrout,
    input  logic             lb_cs,
    input  logic [31:0]      lb_aout,
    input  logic [31:0]      lb_dout,
    output logic [31:0]      lb_din,
    output logic             lb_rdyh,
    input  logic [EVT_W-1:0] evt_in,
    output logic [31:0]      ctrl_out,
    output logic             irq
);

    logic             hit;
    reg_idx_t         idx;
    logic             wr_en;
    logic             locked;
    logic             wr_ctrl;
    logic             wr_status;
    logic             wr_irq_en;
    logic             wr_scratch;
    logic             cnt_clr;
    logic [31:0]      ctrl_q;
    logic [31:0]      scratch_q;
    logic [31:0]      count_q;
    logic [EVT_W-1:0] status_q;
    logic [EVT_W-1:0] irq_en_q;
    logic [EVT_W-1:0] w1c_mask;
    logic [31:0]      status_ext;
    logic [31:0]      irq_en_ext;
    logic [31:0]      rd_data;
    logic             irq_q;
    logic             unused_addr_lsbs;

    // Byte-lane bits of the address carry no meaning for word registers
    assign unused_addr_lsbs = ^lb_aout[1:0];

    assign hit   = (lb_aout[31:5] == BASE_ADDR[31:5]);
    assign idx   = lb_aout[4:2];
    assign wr_en = lb_cs & lb_wrout & hit;

`ifdef LB_REG_LOCK_EN
    assign locked = ctrl_q[CTRL_LOCK];
`else
    assign locked = 1'b0;
`endif

    // STATUS clears stay available while locked so software can still
    // acknowledge interrupts.
    assign wr_ctrl    = wr_en & (idx == IDX_CTRL) & ~locked;
    assign wr_status  = wr_en & (idx == IDX_STATUS);
    assign wr_irq_en  = wr_en & (idx == IDX_IRQ_EN) & ~locked;
    assign wr_scratch = wr_en & (idx == IDX_SCRATCH) & ~locked;
    assign cnt_clr    = wr_ctrl & lb_dout[CTRL_CNT_CLR];
    assign w1c_mask   = wr_status ? lb_dout[EVT_W-1:0] : '0;

    // Plain software registers. The counter-clear bit is masked off so it
    // behaves as a write-only pulse.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_q    <= '0;
            irq_en_q  <= '0;
            scratch_q <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= lb_dout & CTRL_WR_MASK;
            end
            if (wr_irq_en) begin
                irq_en_q <= lb_dout[EVT_W-1:0];
            end
            if (wr_scratch) begin
                scratch_q <= lb_dout;
            end
        end
    end

    // Event status: the clear is applied first and the new events OR'd in
    // afterwards, so an event arriving in the same cycle as its clear wins.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~w1c_mask) | evt_in;
        end
    end

    // Free-running counter gated by CTRL[0]; a clear request on the same edge
    // overrides the increment. Wraps silently.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= '0;
        end else if (ctrl_q[CTRL_CNT_EN]) begin
            count_q <= count_q + 32'd1;
        end
    end

    // Interrupt is registered, lagging STATUS by one clock
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status_q & irq_en_q);
        end
    end

    // Read mux from current register contents; reserved slots read zero.
    always_comb begin
        status_ext             = '0;
        irq_en_ext             = '0;
        status_ext[EVT_W-1:0]  = status_q;
        irq_en_ext[EVT_W-1:0]  = irq_en_q;
        rd_data                = '0;
        case (idx)
            IDX_CTRL:    rd_data = ctrl_q;
            IDX_STATUS:  rd_data = status_ext;
            IDX_IRQ_EN:  rd_data = irq_en_ext;
            IDX_SCRATCH: rd_data = scratch_q;
            IDX_COUNT:   rd_data = count_q;
            IDX_ID:      rd_data = ID_VALUE;
            default:     rd_data = '0;
        endcase
    end

    lb_rd_pipe u_rd_pipe (
        .pclk    (pclk),
        .preset  (preset),
        .hit     (hit),
        .rd_data (rd_data),
        .lb_din  (lb_din),
        .lb_rdyh (lb_rdyh)
    );

    assign ctrl_out = ctrl_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_lb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_lb_reg_bank
// Self-checking bench for lb_reg_bank. Every read pushes its expected
// (rdyh, data) pair onto a queue tagged with the cycle it is due; after each
// clock the due entries are popped and compared against the bus. Interrupt
// and ctrl_out are compared directly inside the scenario tasks.
// Honours LB_REG_LOCK_EN to select the lock or plain CTRL[31] scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lb_reg_bank;

    localparam logic [31:0] BASE      = 32'hA000_0000;
    localparam logic [31:0] ID_VAL    = 32'h0001_0100;
    localparam int          EVT_W     = 8;
    localparam logic [31:0] MISS_ADDR = BASE + 32'h40;

    logic             pclk;
    logic             preset;
    logic             lb_wrout;
    logic             lb_cs;
    logic [31:0]      lb_aout;
    logic [31:0]      lb_dout;
    logic [31:0]      lb_din;
    logic             lb_rdyh;
    logic [EVT_W-1:0] evt_in;
    logic [31:0]      ctrl_out;
    logic             irq;

    typedef struct {
        int          due;
        logic        rdyh;
        logic [31:0] din;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    lb_reg_bank #(
        .BASE_ADDR (BASE),
        .ID_VALUE  (ID_VAL),
        .EVT_W     (EVT_W)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .lb_wrout (lb_wrout),
        .lb_cs    (lb_cs),
        .lb_aout  (lb_aout),
        .lb_dout  (lb_dout),
        .lb_din   (lb_din),
        .lb_rdyh  (lb_rdyh),
        .evt_in   (evt_in),
        .ctrl_out (ctrl_out),
        .irq      (irq)
    );

    // Free-running clock and a cycle counter used to time scoreboard entries
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial cyc = 0;
    always @(posedge pclk) cyc++;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pop every expected read that is due this cycle and compare with the bus
    task automatic sb_pop_due();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (lb_rdyh !== e.rdyh || lb_din !== e.din) begin
                miscompares++;
                $display("[TB] FAIL %s: got rdyh=%0b din=%08h, required rdyh=%0b din=%08h",
                         e.name, lb_rdyh, lb_din, e.rdyh, e.din);
            end
        end
    endtask

    // One bus cycle: drive inputs, optionally queue the read expectation,
    // clock, then settle and retire due entries.
    task automatic step(input logic [31:0] addr, input logic cs, input logic wr,
                        input logic [31:0] wdata, input logic [EVT_W-1:0] evt,
                        input bit chk, input logic rdyh, input logic [31:0] din,
                        input string name);
        exp_t e;
        lb_aout  = addr;
        lb_cs    = cs;
        lb_wrout = wr;
        lb_dout  = wdata;
        evt_in   = evt;
        if (chk) begin
            e.due  = cyc + 2;
            e.rdyh = rdyh;
            e.din  = din;
            e.name = name;
            exp_q.push_back(e);
        end
        @(posedge pclk);
        #1;
        sb_pop_due();
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
        step(BASE + ofs, 1'b1, 1'b1, data, '0, 1'b0, 1'b0, '0, "");
    endtask

    task automatic rd(input logic [31:0] ofs, input logic [31:0] expv, input string name);
        step(BASE + ofs, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, expv, name);
    endtask

    task automatic rd_miss(input logic [31:0] addr, input string name);
        step(addr, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(MISS_ADDR, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, "");
        end
    endtask

    // Reset values, then every register read once; the first read is issued
    // right after reset release and lands two clocks later.
    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        vectors++;
        if (lb_rdyh !== 1'b0 || lb_din !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got rdyh=%0b din=%08h, required 0/00000000", lb_rdyh, lb_din);
        end
        vectors++;
        if (irq !== 1'b0 || ctrl_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outs: got irq=%0b ctrl_out=%08h, required 0/00000000", irq, ctrl_out);
        end
        preset = 1'b0;
        rd(32'h00, 32'h0, "reset_ctrl");
        rd(32'h04, 32'h0, "reset_status");
        rd(32'h08, 32'h0, "reset_irq_en");
        rd(32'h0C, 32'h0, "reset_scratch");
        rd(32'h10, 32'h0, "reset_count");
        rd(32'h14, ID_VAL, "reset_id");
        idle(2);
    endtask

    // SCRATCH write/readback, pipeline follow-through and read-before-write
    task automatic test_scratch();
        wr(32'h0C, 32'hDEAD_BEEF);
        rd(32'h0C, 32'hDEAD_BEEF, "scratch_read");
        rd_miss(MISS_ADDR, "rdyh_follows_next_addr");
        step(BASE + 32'h0C, 1'b1, 1'b1, 32'h1234_5678, '0, 1'b1, 1'b1, 32'hDEAD_BEEF, "read_before_write");
        rd(32'h0C, 32'h1234_5678, "scratch_new");
        rd(32'h00, 32'h0, "ctrl_untouched");
        idle(2);
    endtask

    // Address decode: misses, ignored writes, reserved slots, byte bits
    task automatic test_miss();
        rd_miss(BASE + 32'h40, "miss_base_plus_40");
        rd_miss((BASE ^ 32'h8000_0000) + 32'h0C, "miss_upper_bit");
        step(BASE + 32'h4C, 1'b1, 1'b1, 32'h55, '0, 1'b0, 1'b0, '0, "");
        step(BASE + 32'h0C, 1'b1, 1'b0, 32'h66, '0, 1'b0, 1'b0, '0, "");
        step(BASE + 32'h0C, 1'b0, 1'b1, 32'h77, '0, 1'b0, 1'b0, '0, "");
        rd(32'h0F, 32'h1234_5678, "no_stray_write_low_bits_ignored");
        rd(32'h18, 32'h0, "reserved_18");
        wr(32'h1C, 32'hFFFF_FFFF);
        rd(32'h1C, 32'h0, "reserved_1c");
        idle(2);
    endtask

    // STATUS event capture, W1C, set-wins and the registered interrupt
    task automatic test_irq();
        wr(32'h08, 32'hFFFF_FF04);
        step(MISS_ADDR, 1'b0, 1'b0, '0, 8'h05, 1'b0, 1'b0, '0, "");
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_lag: got irq=%0b, required 0", irq);
        end
        idle(1);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_assert: got irq=%0b, required 1", irq);
        end
        rd(32'h04, 32'h05, "status_events");
        rd(32'h08, 32'h04, "irq_en_upper_zero");
        wr(32'h04, 32'h04);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_hold_on_clear_edge: got irq=%0b, required 1", irq);
        end
        idle(1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_drop: got irq=%0b, required 0", irq);
        end
        rd(32'h04, 32'h01, "status_w1c");
        step(BASE + 32'h04, 1'b1, 1'b1, 32'h01, 8'h01, 1'b0, 1'b0, '0, "");
        rd(32'h04, 32'h01, "status_set_wins");
        wr(32'h04, 32'h01);
        rd(32'h04, 32'h00, "status_cleared");
        step(MISS_ADDR, 1'b0, 1'b0, '0, 8'h80, 1'b0, 1'b0, '0, "");
        step(MISS_ADDR, 1'b0, 1'b0, '0, 8'h02, 1'b0, 1'b0, '0, "");
        rd(32'h04, 32'h82, "status_accumulate");
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_masked: got irq=%0b, required 0", irq);
        end
        wr(32'h04, 32'hFFFF_FFFF);
        rd(32'h04, 32'h00, "status_clear_all");
        idle(2);
    endtask

    // Counter enable, clear pulse, clear priority and read-only registers
    task automatic test_count();
        wr(32'h00, 32'h1);
        vectors++;
        if (ctrl_out !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL ctrl_out_enable: got %08h, required 00000001", ctrl_out);
        end
        idle(9);
        wr(32'h00, 32'h0);
        rd(32'h10, 32'd10, "count_ten");
        rd(32'h00, 32'h0, "ctrl_off");
        wr(32'h00, 32'h3);
        vectors++;
        if (ctrl_out !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL ctrl_out_clr_hidden: got %08h, required 00000001", ctrl_out);
        end
        rd(32'h10, 32'h0, "count_cleared");
        rd(32'h00, 32'h1, "ctrl_clr_reads_0");
        rd(32'h10, 32'h2, "count_restarts");
        wr(32'h00, 32'h3);
        rd(32'h10, 32'h0, "clear_beats_increment");
        wr(32'h00, 32'h0);
        rd(32'h10, 32'h2, "count_frozen");
        wr(32'h10, 32'h0000_FFFF);
        rd(32'h10, 32'h2, "count_write_ignored");
        wr(32'h14, 32'h0);
        rd(32'h14, ID_VAL, "id_write_ignored");
        wr(32'h00, 32'h2);
        rd(32'h10, 32'h0, "count_clear_no_enable");
        rd(32'h00, 32'h0, "ctrl_after_clear");
        idle(2);
    endtask

    // Asynchronous reset while a read is in flight and outputs are active
    task automatic test_reset_in_flight();
        wr(32'h0C, 32'hA5A5_0001);
        wr(32'h08, 32'h01);
        step(MISS_ADDR, 1'b0, 1'b0, '0, 8'h01, 1'b0, 1'b0, '0, "");
        wr(32'h00, 32'h1);
        step(BASE + 32'h0C, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, "");
        step(BASE + 32'h0C, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, "");
        vectors++;
        if (lb_rdyh !== 1'b1 || irq !== 1'b1 || ctrl_out !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_active: got rdyh=%0b irq=%0b ctrl_out=%08h, required 1/1/00000001",
                     lb_rdyh, irq, ctrl_out);
        end
        preset = 1'b1;
        #1;
        vectors++;
        if (lb_rdyh !== 1'b0 || lb_din !== 32'h0 || irq !== 1'b0 || ctrl_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_flush: got rdyh=%0b din=%08h irq=%0b ctrl_out=%08h, required all 0",
                     lb_rdyh, lb_din, irq, ctrl_out);
        end
        exp_q.delete();
        @(posedge pclk);
        #1;
        preset = 1'b0;
        rd(32'h00, 32'h0, "rst_ctrl");
        rd(32'h04, 32'h0, "rst_status");
        rd(32'h08, 32'h0, "rst_irq_en");
        rd(32'h0C, 32'h0, "rst_scratch");
        rd(32'h10, 32'h0, "rst_count");
        idle(2);
    endtask

`ifdef LB_REG_LOCK_EN
    // Sticky lock: CTRL / IRQ_EN / SCRATCH frozen, STATUS W1C still works
    task automatic test_lock();
        wr(32'h0C, 32'h0000_1111);
        wr(32'h00, 32'h8000_0000);
        vectors++;
        if (ctrl_out !== 32'h8000_0000) begin
            miscompares++;
            $display("[TB] FAIL lock_ctrl_out: got %08h, required 80000000", ctrl_out);
        end
        wr(32'h0C, 32'h0000_1234);
        wr(32'h08, 32'h0000_00FF);
        wr(32'h00, 32'h0);
        rd(32'h0C, 32'h0000_1111, "lock_scratch_frozen");
        rd(32'h08, 32'h0, "lock_irq_en_frozen");
        rd(32'h00, 32'h8000_0000, "lock_ctrl_sticky");
        step(MISS_ADDR, 1'b0, 1'b0, '0, 8'h02, 1'b0, 1'b0, '0, "");
        rd(32'h04, 32'h02, "lock_status_set");
        wr(32'h04, 32'h02);
        rd(32'h04, 32'h00, "lock_status_w1c");
        idle(2);
    endtask
`else
    // Without the lock option CTRL[31] is an ordinary bit
    task automatic test_lock();
        wr(32'h0C, 32'h0000_1111);
        wr(32'h00, 32'h8000_0000);
        wr(32'h0C, 32'h0000_1234);
        rd(32'h0C, 32'h0000_1234, "nolock_scratch_writable");
        rd(32'h00, 32'h8000_0000, "nolock_ctrl_bit31");
        wr(32'h00, 32'h0);
        rd(32'h00, 32'h0, "nolock_ctrl_cleared");
        idle(2);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        preset      = 1'b1;
        lb_wrout    = 1'b0;
        lb_cs       = 1'b0;
        lb_aout     = MISS_ADDR;
        lb_dout     = '0;
        evt_in      = '0;
        $display("[TB] starting lb_reg_bank bench");
        test_reset();
        test_scratch();
        test_miss();
        test_irq();
        test_count();
        test_reset_in_flight();
        test_lock();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending reads, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
